// File: rtl/dcache_sram_nway.sv
// N-way set-associative tag/data store with valid/dirty bits, true-LRU age counters
// and dirty-victim export; one request per cycle, one cycle registered latency.
module dcache_sram_nway #(
  parameter int SET_BITS = 4,
  parameter int WAYS     = 2,
  parameter int TAG_W    = 25,
  parameter int LINE_W   = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     write_i,
  input  logic                     fill_i,
  input  logic                     dirty_i,
  input  logic [SET_BITS-1:0]      addr_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [LINE_W-1:0]        data_i,
  output logic                     valid_o,
  output logic                     hit_o,
  output logic [$clog2(WAYS)-1:0]  way_o,
  output logic [LINE_W-1:0]        data_o,
  output logic                     evict_o,
  output logic [TAG_W-1:0]         evict_tag_o,
  output logic [LINE_W-1:0]        evict_data_o
);

  localparam int AGE_W = $clog2(WAYS);
  localparam int SETS  = 1 << SET_BITS;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  logic             hit_any;
  logic             inv_any;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] victim;
  logic [AGE_W-1:0] touch_way;
  logic             is_fill;
  logic             do_touch;

  // Tag match, first invalid way and oldest way of the addressed set, from current state.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i) && !hit_any) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[addr_i][w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(w);
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
        lru_way = AGE_W'(w);
      end
    end
  end

  always_comb begin
    is_fill   = write_i & fill_i;
    victim    = inv_any ? inv_way : lru_way;
    touch_way = is_fill ? victim : hit_way;
    do_touch  = req_i & (is_fill | hit_any);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
      valid_o      <= 1'b0;
      hit_o        <= 1'b0;
      way_o        <= '0;
      data_o       <= '0;
      evict_o      <= 1'b0;
      evict_tag_o  <= '0;
      evict_data_o <= '0;
    end else begin
      valid_o      <= req_i;
      hit_o        <= 1'b0;
      way_o        <= '0;
      data_o       <= '0;
      evict_o      <= 1'b0;
      evict_tag_o  <= '0;
      evict_data_o <= '0;
      if (req_i) begin
        if (is_fill) begin
          way_o <= victim;
          if (valid_q[addr_i][victim] && dirty_q[addr_i][victim]) begin
            evict_o      <= 1'b1;
            evict_tag_o  <= tag_q[addr_i][victim];
            evict_data_o <= data_q[addr_i][victim];
          end
          valid_q[addr_i][victim] <= 1'b1;
          dirty_q[addr_i][victim] <= dirty_i;
          tag_q[addr_i][victim]   <= tag_i;
          data_q[addr_i][victim]  <= data_i;
        end else if (hit_any) begin
          hit_o <= 1'b1;
          way_o <= hit_way;
          if (write_i) begin
            data_q[addr_i][hit_way]  <= data_i;
            dirty_q[addr_i][hit_way] <= 1'b1;
            data_o                   <= data_i;
          end else begin
            data_o <= data_q[addr_i][hit_way];
          end
        end
        // Younger-than-touched ways age by one; the touched way becomes youngest.
        if (do_touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touch_way) begin
              age_q[addr_i][w] <= '0;
            end else if (age_q[addr_i][w] < age_q[addr_i][touch_way]) begin
              age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Drives a 2-way and a 4-way instance with identical requests and compares both against
// a recency-list reference model of the cache.
module tb_dcache_sram_nway;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         write_i = 1'b0;
  logic         fill_i = 1'b0;
  logic         dirty_i = 1'b0;
  logic [3:0]   addr_i = '0;
  logic [24:0]  tag_i = '0;
  logic [255:0] data_i = '0;

  logic         valid2, hit2, evict2, valid4, hit4, evict4;
  logic [0:0]   way2;
  logic [1:0]   way4;
  logic [24:0]  etag2, etag4;
  logic [255:0] data2, data4, edata2, edata4;

  dcache_sram_nway #(.SET_BITS(4), .WAYS(2), .TAG_W(25), .LINE_W(256)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .fill_i(fill_i),
    .dirty_i(dirty_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .valid_o(valid2), .hit_o(hit2), .way_o(way2), .data_o(data2),
    .evict_o(evict2), .evict_tag_o(etag2), .evict_data_o(edata2)
  );

  dcache_sram_nway #(.SET_BITS(4), .WAYS(4), .TAG_W(25), .LINE_W(256)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .fill_i(fill_i),
    .dirty_i(dirty_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .valid_o(valid4), .hit_o(hit4), .way_o(way4), .data_o(data4),
    .evict_o(evict4), .evict_tag_o(etag4), .evict_data_o(edata4)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         valid;
    logic         hit;
    logic [2:0]   way;
    logic         evict;
    logic [24:0]  etag;
    logic [255:0] data;
    logic [255:0] edata;
  } resp_t;

  resp_t act2, act4, exp2, exp4;
  int checks = 0;
  int failures = 0;

  // Reference model: index 0 = 2-way instance, 1 = 4-way instance.
  // m_order holds way numbers from most to least recently used; a way's age is its position.
  int           m_ways  [2];
  bit           m_valid [2][16][8];
  bit           m_dirty [2][16][8];
  logic [24:0]  m_tag   [2][16][8];
  logic [255:0] m_data  [2][16][8];
  int           m_order [2][16][8];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 8; w++) begin
          m_valid[k][s][w] = 1'b0;
          m_dirty[k][s][w] = 1'b0;
          m_tag[k][s][w]   = '0;
          m_data[k][s][w]  = '0;
          m_order[k][s][w] = w;
        end
  endfunction

  function automatic int model_hit_way(int k, int s, logic [24:0] t);
    for (int w = 0; w < m_ways[k]; w++)
      if (m_valid[k][s][w] && m_tag[k][s][w] == t) return w;
    return -1;
  endfunction

  function automatic int model_age(int k, int s, int w);
    for (int p = 0; p < m_ways[k]; p++)
      if (m_order[k][s][p] == w) return p;
    return -1;
  endfunction

  function automatic void model_touch(int k, int s, int w);
    int p;
    p = model_age(k, s, w);
    for (int i = p; i > 0; i--) m_order[k][s][i] = m_order[k][s][i-1];
    m_order[k][s][0] = w;
  endfunction

  function automatic resp_t model_req(int k, bit wr, bit fill, bit dirty, int s,
                                      logic [24:0] t, logic [255:0] d);
    resp_t r;
    int hw;
    int v;
    r = '0;
    r.valid = 1'b1;
    hw = model_hit_way(k, s, t);
    if (wr && fill) begin
      v = -1;
      for (int w = 0; w < m_ways[k]; w++)
        if (!m_valid[k][s][w] && v < 0) v = w;
      if (v < 0) v = m_order[k][s][m_ways[k]-1];
      r.way = 3'(v);
      if (m_valid[k][s][v] && m_dirty[k][s][v]) begin
        r.evict = 1'b1;
        r.etag  = m_tag[k][s][v];
        r.edata = m_data[k][s][v];
      end
      m_valid[k][s][v] = 1'b1;
      m_dirty[k][s][v] = dirty;
      m_tag[k][s][v]   = t;
      m_data[k][s][v]  = d;
      model_touch(k, s, v);
    end else if (hw >= 0) begin
      r.hit = 1'b1;
      r.way = 3'(hw);
      if (wr) begin
        m_data[k][s][hw]  = d;
        m_dirty[k][s][hw] = 1'b1;
        r.data = d;
      end else begin
        r.data = m_data[k][s][hw];
      end
      model_touch(k, s, hw);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic sample();
    act2 = '{valid:valid2, hit:hit2, way:3'(way2), evict:evict2, etag:etag2, data:data2, edata:edata2};
    act4 = '{valid:valid4, hit:hit4, way:3'(way4), evict:evict4, etag:etag4, data:data4, edata:edata4};
  endtask

  task automatic run_req(input bit wr, input bit fill, input bit dirty, input int s,
                         input logic [24:0] t, input logic [255:0] d);
    req_i = 1'b1; write_i = wr; fill_i = fill; dirty_i = dirty;
    addr_i = 4'(s); tag_i = t; data_i = d;
    exp2 = model_req(0, wr, fill, dirty, s, t, d);
    exp4 = model_req(1, wr, fill, dirty, s, t, d);
    @(posedge clk_i); #1;
    sample();
    req_i = 1'b0; write_i = 1'b0; fill_i = 1'b0;
  endtask

  task automatic run_idle();
    req_i = 1'b0;
    exp2 = '0;
    exp4 = '0;
    @(posedge clk_i); #1;
    sample();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    sample();
    checks++;
    if (act2 !== '0) begin failures++; $display("FAIL reset_w2 got=%h exp=0", act2); end
    checks++;
    if (act4 !== '0) begin failures++; $display("FAIL reset_w4 got=%h exp=0", act4); end
    run_req(0, 0, 0, 3, 25'h1, '0);
    checks++;
    if (act2 !== exp2) begin failures++; $display("FAIL first_lookup_w2 got=%h exp=%h", act2, exp2); end
    checks++;
    if (act4 !== exp4) begin failures++; $display("FAIL first_lookup_w4 got=%h exp=%h", act4, exp4); end
    checks++;
    if (act2.valid !== 1'b1 || act2.hit !== 1'b0 || act2.data !== '0) begin
      failures++; $display("FAIL first_lookup_miss got valid=%b hit=%b exp valid=1 hit=0", act2.valid, act2.hit);
    end
  endtask

  task automatic test_fill_lookup();
    logic [255:0] a5;
    a5 = {8{32'hA5A5A5A5}};
    run_req(1, 1, 0, 3, 25'h1, a5);
    checks++;
    if (act2 !== exp2) begin failures++; $display("FAIL fill_w2 got=%h exp=%h", act2, exp2); end
    checks++;
    if (act4.way !== 3'd0 || act4.evict !== 1'b0) begin
      failures++; $display("FAIL fill_way got way=%0d evict=%b exp way=0 evict=0", act4.way, act4.evict);
    end
    run_req(0, 0, 0, 3, 25'h1, '0);
    checks++;
    if (act4 !== exp4) begin failures++; $display("FAIL hit_w4 got=%h exp=%h", act4, exp4); end
    checks++;
    if (act2.hit !== 1'b1 || act2.way !== 3'd0 || act2.data !== a5) begin
      failures++; $display("FAIL hit_data got hit=%b data=%h exp hit=1 data=%h", act2.hit, act2.data, a5);
    end
  endtask

  task automatic test_ways2_evict();
    bit          wr [5]  = '{1, 1, 0, 1, 1};
    bit          dty [5] = '{1, 0, 0, 0, 0};
    logic [24:0] tg [5]  = '{25'h10, 25'h20, 25'h10, 25'h30, 25'h40};
    for (int i = 0; i < 5; i++) begin
      run_req(wr[i], wr[i], dty[i], 5, tg[i], rand_line());
      checks++;
      if (act2 !== exp2) begin failures++; $display("FAIL w2evict[%0d]_w2 got=%h exp=%h", i, act2, exp2); end
      checks++;
      if (act4 !== exp4) begin failures++; $display("FAIL w2evict[%0d]_w4 got=%h exp=%h", i, act4, exp4); end
      if (i == 3) begin
        checks++;
        if (act2.way !== 3'd1 || act2.evict !== 1'b0) begin
          failures++; $display("FAIL clean_victim got way=%0d evict=%b exp way=1 evict=0", act2.way, act2.evict);
        end
      end
      if (i == 4) begin
        checks++;
        if (act2.way !== 3'd0 || act2.evict !== 1'b1 || act2.etag !== 25'h10) begin
          failures++; $display("FAIL dirty_victim got way=%0d evict=%b tag=%h exp way=0 evict=1 tag=10",
                               act2.way, act2.evict, act2.etag);
        end
      end
    end
  endtask

  task automatic test_write_dirty();
    bit           wr [7]  = '{1, 1, 1, 1, 0, 0, 1};
    bit           fl [7]  = '{1, 1, 0, 0, 0, 0, 1};
    logic [24:0]  tg [7]  = '{25'h50, 25'h60, 25'h50, 25'h70, 25'h50, 25'h60, 25'h80};
    logic [255:0] wdata;
    logic [255:0] d;
    wdata = rand_line();
    for (int i = 0; i < 7; i++) begin
      d = (i == 2) ? wdata : rand_line();
      run_req(wr[i], fl[i], 1'b0, 6, tg[i], d);
      checks++;
      if (act2 !== exp2) begin failures++; $display("FAIL wdirty[%0d]_w2 got=%h exp=%h", i, act2, exp2); end
      checks++;
      if (act4 !== exp4) begin failures++; $display("FAIL wdirty[%0d]_w4 got=%h exp=%h", i, act4, exp4); end
      if (i == 3) begin
        checks++;
        if (act2.hit !== 1'b0) begin failures++; $display("FAIL write_miss got hit=%b exp hit=0", act2.hit); end
      end
      if (i == 6) begin
        checks++;
        if (act2.evict !== 1'b1 || act2.etag !== 25'h50 || act2.edata !== wdata) begin
          failures++; $display("FAIL write_evict got evict=%b tag=%h data=%h exp evict=1 tag=50 data=%h",
                               act2.evict, act2.etag, act2.edata, wdata);
        end
      end
    end
  endtask

  task automatic test_ways4_lru();
    bit          wr [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [24:0] tg [9] = '{25'h1, 25'h2, 25'h3, 25'h4, 25'h3, 25'h1, 25'h4, 25'h5, 25'h6};
    for (int i = 0; i < 9; i++) begin
      run_req(wr[i], wr[i], 1'($urandom), 0, tg[i], rand_line());
      checks++;
      if (act2 !== exp2) begin failures++; $display("FAIL lru4[%0d]_w2 got=%h exp=%h", i, act2, exp2); end
      checks++;
      if (act4 !== exp4) begin failures++; $display("FAIL lru4[%0d]_w4 got=%h exp=%h", i, act4, exp4); end
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (u_dut4.age_q[0][w] !== 2'(model_age(1, 0, w))) begin
          failures++; $display("FAIL age[%0d][way%0d] got=%0d exp=%0d", i, w, u_dut4.age_q[0][w], model_age(1, 0, w));
        end
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (act4.way !== 3'(i - 6)) begin
          failures++; $display("FAIL lru_victim[%0d] got way=%0d exp way=%0d", i, act4.way, i - 6);
        end
      end
    end
  endtask

  task automatic test_random();
    int           op;
    int           s;
    logic [24:0]  t;
    bit           fl;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 4);
      s  = $urandom_range(0, 3);
      t  = 25'($urandom_range(1, 6));
      if (op == 4) begin
        run_idle();
      end else begin
        fl = (op >= 2);
        if (fl && (model_hit_way(0, s, t) >= 0 || model_hit_way(1, s, t) >= 0)) fl = 1'b0;
        run_req(op != 0, fl, 1'($urandom), s, t, rand_line());
      end
      checks++;
      if (act2 !== exp2) begin failures++; $display("FAIL rand[%0d]_w2 got=%h exp=%h", i, act2, exp2); end
      checks++;
      if (act4 !== exp4) begin failures++; $display("FAIL rand[%0d]_w4 got=%h exp=%h", i, act4, exp4); end
    end
  endtask

  task automatic test_async_reset();
    run_req(1, 1, 1, 9, 25'h77, rand_line());
    run_req(0, 0, 0, 9, 25'h77, '0);
    checks++;
    if (act4 !== exp4 || act4.hit !== 1'b1) begin failures++; $display("FAIL pre_reset_hit got=%h exp=%h", act4, exp4); end
    req_i = 1'b1; write_i = 1'b1; fill_i = 1'b1; addr_i = 4'd9; tag_i = 25'h88; data_i = rand_line();
    #3;
    rst_i = 1'b1;
    #1;
    sample();
    checks++;
    if (act2 !== '0) begin failures++; $display("FAIL async_rst_w2 got=%h exp=0", act2); end
    checks++;
    if (act4 !== '0) begin failures++; $display("FAIL async_rst_w4 got=%h exp=0", act4); end
    @(posedge clk_i); #1;
    sample();
    checks++;
    if (act4 !== '0) begin failures++; $display("FAIL rst_hold_w4 got=%h exp=0", act4); end
    rst_i = 1'b0;
    req_i = 1'b0; write_i = 1'b0; fill_i = 1'b0;
    model_reset();
    run_req(0, 0, 0, 9, 25'h77, '0);
    checks++;
    if (act2 !== exp2 || act2.hit !== 1'b0) begin failures++; $display("FAIL post_rst_old_w2 got=%h exp=%h", act2, exp2); end
    run_req(0, 0, 0, 9, 25'h88, '0);
    checks++;
    if (act4 !== exp4 || act4.hit !== 1'b0) begin failures++; $display("FAIL dropped_fill_w4 got=%h exp=%h", act4, exp4); end
  endtask

  initial begin
    m_ways[0] = 2;
    m_ways[1] = 4;
    model_reset();
    test_reset();
    test_fill_lookup();
    test_ways2_evict();
    test_write_dirty();
    test_ways4_lru();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
# dcache_sram_nway

Parametrised N-way set-associative tag/data store for the L1 data cache, replacing the fixed 2-way array. It holds per-line valid and dirty bits and true-LRU age counters. It performs one lookup, write-hit or fill per cycle and returns results with one cycle of registered latency. On a fill that displaces a dirty line, it exports the victim so the controller can write it back to memory.

## Interface
- SET_BITS, 4: set index width; sets = 2^SET_BITS.
- WAYS, 2: associativity; legal values 2, 4, 8.
- TAG_W, 25: tag width.
- LINE_W, 256: cache line width in bits.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid this cycle.
- write_i  in  1  0 = lookup, 1 = write.
- fill_i  in  1  with write_i=1: allocate/fill (miss refill); ignored when write_i=0.
- dirty_i  in  1  dirty value stored on fill.
- addr_i  in  SET_BITS  set index.
- tag_i  in  TAG_W  request tag.
- data_i  in  LINE_W  write/fill data.
- valid_o  out  1  response valid (request accepted the previous cycle).
- hit_o  out  1  tag matched a valid way.
- way_o  out  clog2(WAYS)  hit way, or the filled way on fill.
- data_o  out  LINE_W  hit line data (lookup); 0 on miss.
- evict_o  out  1  fill displaced a valid dirty line.
- evict_tag_o  out  TAG_W  victim tag when evict_o=1, else 0.
- evict_data_o  out  LINE_W  victim data when evict_o=1, else 0.

## Operation
- Per set, per way: valid, dirty, tag, data, age[AGE_W-1:0], AGE_W = clog2(WAYS).
- Hit: some way w has valid=1 and tag==tag_i. At most one way can match, because fills never duplicate a tag (controller guarantee).
- Lookup (req_i=1, write_i=0):
  - Hit: data_o=data[w], way_o=w, and LRU is touched.
  - Miss: hit_o=0, data_o=0, way_o=0, and no state changes.
- Write (write_i=1, fill_i=0):
  - Hit: data[w]<=data_i, dirty[w]<=1, LRU is touched, hit_o=1, way_o=w, data_o=data_i.
  - Miss: no state change and hit_o=0.
- Fill (write_i=1, fill_i=1):
  - Victim v is the lowest-index invalid way. If none is invalid, v is the way with age==WAYS-1.
  - Write tag_i, data_i, valid=1, dirty=dirty_i into v. LRU is touched on v.
  - Outputs: hit_o=0, way_o=v, data_o=0.
  - evict_o=1 only if v was valid and dirty before the fill; evict_tag_o/evict_data_o then carry the old contents.
  - A fill whose tag already hits is a controller error; behaviour is undefined.
- LRU touch of way w with old age a: every way in the set with age<a increments, and age[w]<=0. Ages in a set always form a permutation of 0..WAYS-1.
- Idle (req_i=0): no state change; valid_o=0 and all other outputs 0.

## Timing
- Array update and output register both occur on the rising edge that samples req_i=1. Response is visible the following cycle with valid_o=1.
- Throughput is one request per cycle with no stall.
- Back-to-back requests to the same set see the prior cycle's write/fill/LRU update. The array is read combinationally from post-edge state.
- Reset (asynchronous, any time, including mid-stream):
  - All valid=0, dirty=0, tag=0, data=0, age[set][w]=w.
  - All outputs 0; valid_o=0.
  - A request sampled in the same cycle as reset is dropped.
- After reset deassertion, the first edge with req_i=1 is a normal request.

## Test plan
- Reset, then lookup set 3 tag 0x1 -> valid_o=1, hit_o=0, data_o=0 one cycle later; array unchanged.
- Fill set 3 tag 0x1 data 0xA5.., dirty_i=0 -> way_o=0, evict_o=0. Next-cycle lookup tag 0x1 -> hit_o=1, way_o=0, data_o=0xA5...
- WAYS=2, set 5:
  - Fill tag 0x10 dirty=1 (way 0), then fill tag 0x20 (way 1). Lookup 0x10 makes way 1 the LRU.
  - Fill tag 0x30 -> way_o=1, evict_o=0 (way 1 was clean).
  - Fill tag 0x40 -> way_o=0, evict_o=1, evict_tag_o=0x10.
- Write hit to a clean line -> dirty set. A later fill evicting that line -> evict_o=1 with data_i of the write; a write miss leaves all ways unchanged.
- WAYS=4:
  - Fill 4 tags into set 0, then touch ways in order 2,0,3.
  - Next fill victimises way 1; the following fill victimises way 2. Check age permutation each step.
- Assert rst_i asynchronously between two requests -> outputs 0 immediately; a subsequent lookup of a previously filled tag misses.
